instr_fetch_queue: RTL and testbench

Fetch stage sitting directly downstream of `program_counter`. Takes the current `PC`, issues word reads to instruction memory over a valid/ready request port, and buffers returned instructions with their PCs in a small FIFO. Presents them to decode over a valid/ready handshake. Drives `PCEn` so the PC advances only when a fetch is accepted, and discards all queued and in-flight fetches on a redirect (`Flush`).

---
 rtl/ifq_pkg.sv | 19 +
 rtl/ifq_fifo.sv | 60 ++++++
 rtl/instr_fetch_queue.sv | 111 +++++++++++
 tb/tb_instr_fetch_queue.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: FSM states, FIFO entry layout
// and the instruction value presented while nothing has been fetched.
package ifq_pkg;

   localparam int IFQ_XLEN = 32;
   localparam logic [IFQ_XLEN-1:0] IFQ_RESET_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } ifq_state_t;

   typedef struct packed {
      logic [IFQ_XLEN-1:0] pc;
      logic [IFQ_XLEN-1:0] instr;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of fetched {pc, instr} entries with push, pop and a clear
// that drops every queued entry; clear takes priority over push and pop.
module ifq_fifo
   import ifq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic                     clear,
   input  logic                     push,
   input  ifq_entry_t               push_entry,
   input  logic                     pop,
   output ifq_entry_t               head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   ifq_entry_t    storage [DEPTH];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            storage[i] <= '{pc: '0, instr: IFQ_RESET_INSTR};
         end
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            storage[wr_ptr] <= push_entry;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   assign head  = storage[rd_ptr];
   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: one outstanding instruction-memory read, results queued for decode.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module instr_fetch_queue
   import ifq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic [XLEN-1:0] PC,
   input  logic            Flush,
   output logic            PCEn,
   output logic            IMemReqValid,
   output logic [XLEN-1:0] IMemReqAddr,
   input  logic            IMemReqReady,
   input  logic            IMemRspValid,
   input  logic [XLEN-1:0] IMemRspData,
   output logic            InstrValid,
   output logic [XLEN-1:0] Instr,
   output logic [XLEN-1:0] InstrPC,
   input  logic            InstrReady
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

   ifq_state_t      state;
   ifq_state_t      state_next;
   logic [XLEN-1:0] req_pc;

   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [PW:0]     fifo_count;
   ifq_entry_t      fifo_head;
   ifq_entry_t      push_entry;
   logic            rsp_accept;

   // State register and the PC of the single request in flight.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         req_pc <= '0;
      end else begin
         state <= state_next;
         if (PCEn) begin
            req_pc <= PC;
         end
      end
   end

   // A flush while waiting leaves a response still owed by memory; DROP swallows it.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (PCEn) state_next = WAIT;
         WAIT: begin
            if (IMemRspValid) begin
               state_next = IDLE;
            end else if (Flush) begin
               state_next = DROP;
            end
         end
         DROP: if (IMemRspValid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Issuing only with a free slot means every response always finds room.
   assign IMemReqValid = (state == IDLE) & (fifo_count < DEPTH_CNT) & ~Flush & ~Reset;
   assign IMemReqAddr  = PC;
   assign PCEn         = IMemReqValid & IMemReqReady;

   assign rsp_accept = (state == WAIT) & IMemRspValid & ~Flush;
   assign push_entry = '{pc: req_pc, instr: IMemRspData};
   assign fifo_pop   = ~fifo_empty & InstrReady & ~Flush;

`ifdef IFQ_BYPASS_EN
   logic bypass;

   // An instruction consumed on its response cycle never needs a slot.
   assign bypass     = fifo_empty & rsp_accept;
   assign fifo_push  = rsp_accept & ~fifo_full & ~(bypass & InstrReady);
   assign InstrValid = ~fifo_empty | bypass;
   assign Instr      = bypass ? IMemRspData : fifo_head.instr;
   assign InstrPC    = bypass ? req_pc      : fifo_head.pc;
`else
   assign fifo_push  = rsp_accept & ~fifo_full;
   assign InstrValid = ~fifo_empty;
   assign Instr      = fifo_head.instr;
   assign InstrPC    = fifo_head.pc;
`endif

   ifq_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .Reset     (Reset),
      .clear     (Flush),
      .push      (fifo_push),
      .push_entry(push_entry),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue with a latency-programmable memory
// model and a program-counter model driven from PCEn/Flush.
module tb_instr_fetch_queue;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] PC = '0;
   logic        Flush = 1'b0;
   logic        PCEn;
   logic        IMemReqValid;
   logic [31:0] IMemReqAddr;
   logic        IMemReqReady = 1'b0;
   logic        IMemRspValid = 1'b0;
   logic [31:0] IMemRspData = '0;
   logic        InstrValid;
   logic [31:0] Instr;
   logic [31:0] InstrPC;
   logic        InstrReady = 1'b0;

   int          compared = 0;
   int          mismatched = 0;

   int          memLat = 1;
   bit          memKill = 1'b0;
   bit          memPend = 1'b0;
   int          memCnt = 0;
   logic [31:0] memAddr = '0;
   logic [31:0] flushTarget = '0;
   bit          pcEnS, flushS, resetS;

`ifdef IFQ_BYPASS_EN
   localparam int FIRST_VALID = 1;
   localparam int STREAM_POPS = 6;
`else
   localparam int FIRST_VALID = 2;
   localparam int STREAM_POPS = 5;
`endif

   instr_fetch_queue #(
      .DEPTH(4),
      .XLEN (32)
   ) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .PC          (PC),
      .Flush       (Flush),
      .PCEn        (PCEn),
      .IMemReqValid(IMemReqValid),
      .IMemReqAddr (IMemReqAddr),
      .IMemReqReady(IMemReqReady),
      .IMemRspValid(IMemRspValid),
      .IMemRspData (IMemRspData),
      .InstrValid  (InstrValid),
      .Instr       (Instr),
      .InstrPC     (InstrPC),
      .InstrReady  (InstrReady)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {16'hA5A5, a[15:0]};
   endfunction

   // Memory and PC models: sample at the edge, update 1ns later.
   always @(posedge CLK) begin
      if (memKill) begin
         memPend = 1'b0;
      end else begin
         if (IMemRspValid) memPend = 1'b0;
         if (IMemReqValid && IMemReqReady) begin
            memPend = 1'b1;
            memCnt  = memLat;
            memAddr = IMemReqAddr;
         end
      end
      pcEnS  = PCEn;
      flushS = Flush;
      resetS = Reset;
      #1;
      if (memPend && memCnt > 0) memCnt--;
      IMemRspValid = memPend && (memCnt == 0);
      IMemRspData  = (memPend && memCnt == 0) ? memWord(memAddr) : 32'h0;
      if (resetS)      PC = 32'h0;
      else if (flushS) PC = flushTarget;
      else if (pcEnS)  PC = PC + 32'd4;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge CLK);
      #3;
   endtask

   task automatic doReset();
      Reset = 1'b1;
      Flush = 1'b0;
      InstrReady = 1'b0;
      IMemReqReady = 1'b0;
      memLat = 1;
      memKill = 1'b1;
      tick();
      tick();
      memKill = 1'b0;
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      IMemReqReady = 1'b1;
      InstrReady = 1'b0;
      tick();
      #1;
      compared++; if (IMemReqValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_reqvalid: got %b expected 0", IMemReqValid); end
      compared++; if (PCEn !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pcen: got %b expected 0", PCEn); end
      compared++; if (InstrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_instrvalid: got %b expected 0", InstrValid); end
      compared++; if (Instr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_instr: got %h expected 0", Instr); end
      compared++; if (InstrPC !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_instrpc: got %h expected 0", InstrPC); end
   endtask

   task automatic test_streaming();
      int pops;
      int firstValid;
      logic [31:0] expPc;
      logic expEn;
      doReset();
      IMemReqReady = 1'b1;
      InstrReady = 1'b1;
      pops = 0;
      firstValid = -1;
      expPc = 32'h0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) tick();
         #1;
         expEn = (c % 2 == 0);
         compared++; if (PCEn !== expEn) begin mismatched++; $display("[TB] FAIL stream_pcen c=%0d: got %b expected %b", c, PCEn, expEn); end
         if (InstrValid === 1'b1) begin
            if (firstValid < 0) firstValid = c;
            pops++;
            compared++; if (InstrPC !== expPc) begin mismatched++; $display("[TB] FAIL stream_pc c=%0d: got %h expected %h", c, InstrPC, expPc); end
            compared++; if (Instr !== memWord(expPc)) begin mismatched++; $display("[TB] FAIL stream_instr c=%0d: got %h expected %h", c, Instr, memWord(expPc)); end
            expPc = expPc + 32'd4;
         end
      end
      compared++; if (firstValid != FIRST_VALID) begin mismatched++; $display("[TB] FAIL stream_latency: got %0d expected %0d", firstValid, FIRST_VALID); end
      compared++; if (pops != STREAM_POPS) begin mismatched++; $display("[TB] FAIL stream_count: got %0d expected %0d", pops, STREAM_POPS); end
   endtask

   task automatic test_fill();
      int accepts;
      int pops;
      logic [31:0] expPc;
      doReset();
      IMemReqReady = 1'b1;
      accepts = 0;
      pops = 0;
      expPc = 32'h0;
      for (int c = 0; c < 18; c++) begin
         if (c > 0) tick();
         if (c == 12) InstrReady = 1'b1;
         #1;
         if (c < 12 && PCEn === 1'b1) accepts++;
         if (c >= 8 && c <= 11) begin
            compared++; if (IMemReqValid !== 1'b0) begin mismatched++; $display("[TB] FAIL full_reqvalid c=%0d: got %b expected 0", c, IMemReqValid); end
            compared++; if (PCEn !== 1'b0) begin mismatched++; $display("[TB] FAIL full_pcen c=%0d: got %b expected 0", c, PCEn); end
         end
         if (c == 11) begin
            compared++; if (InstrPC !== 32'h0) begin mismatched++; $display("[TB] FAIL full_hold_pc: got %h expected 0", InstrPC); end
            compared++; if (Instr !== memWord(32'h0)) begin mismatched++; $display("[TB] FAIL full_hold_instr: got %h expected %h", Instr, memWord(32'h0)); end
         end
         if (c == 13) begin
            compared++; if (PCEn !== 1'b1) begin mismatched++; $display("[TB] FAIL resume_pcen: got %b expected 1", PCEn); end
            compared++; if (IMemReqAddr !== 32'h10) begin mismatched++; $display("[TB] FAIL resume_addr: got %h expected 10", IMemReqAddr); end
         end
         if (c >= 12 && InstrValid === 1'b1) begin
            pops++;
            compared++; if (InstrPC !== expPc) begin mismatched++; $display("[TB] FAIL drain_pc c=%0d: got %h expected %h", c, InstrPC, expPc); end
            compared++; if (Instr !== memWord(expPc)) begin mismatched++; $display("[TB] FAIL drain_instr c=%0d: got %h expected %h", c, Instr, memWord(expPc)); end
            expPc = expPc + 32'd4;
         end
      end
      compared++; if (accepts != 4) begin mismatched++; $display("[TB] FAIL fill_accepts: got %0d expected 4", accepts); end
      compared++; if (pops != 6) begin mismatched++; $display("[TB] FAIL drain_count: got %0d expected 6", pops); end
   endtask

   task automatic test_flush_wait();
      doReset();
      IMemReqReady = 1'b1;
      memLat = 3;
      flushTarget = 32'h40;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) tick();
         Flush = (c == 1);
         #1;
         if (c == 2) begin
            compared++; if (IMemReqValid !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_reqvalid: got %b expected 0", IMemReqValid); end
         end
         if (c >= 2 && c <= 6) begin
            compared++; if (InstrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_instrvalid c=%0d: got %b expected 0", c, InstrValid); end
         end
         if (c == 4) begin
            compared++; if (IMemReqValid !== 1'b1) begin mismatched++; $display("[TB] FAIL redirect_reqvalid: got %b expected 1", IMemReqValid); end
            compared++; if (IMemReqAddr !== 32'h40) begin mismatched++; $display("[TB] FAIL redirect_addr: got %h expected 40", IMemReqAddr); end
         end
         if (c == 8) begin
            compared++; if (InstrValid !== 1'b1) begin mismatched++; $display("[TB] FAIL redirect_valid: got %b expected 1", InstrValid); end
            compared++; if (InstrPC !== 32'h40) begin mismatched++; $display("[TB] FAIL redirect_pc: got %h expected 40", InstrPC); end
            compared++; if (Instr !== memWord(32'h40)) begin mismatched++; $display("[TB] FAIL redirect_instr: got %h expected %h", Instr, memWord(32'h40)); end
         end
      end
      Flush = 1'b0;
   endtask

   task automatic test_flush_collide();
      doReset();
      IMemReqReady = 1'b1;
      flushTarget = 32'h80;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) tick();
         Flush = (c == 3);
         InstrReady = (c == 3);
         #1;
         if (c == 3) begin
            compared++; if (InstrValid !== 1'b1) begin mismatched++; $display("[TB] FAIL collide_pre_valid: got %b expected 1", InstrValid); end
         end
         if (c == 4) begin
            compared++; if (InstrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL collide_empty: got %b expected 0", InstrValid); end
            compared++; if (IMemReqValid !== 1'b1) begin mismatched++; $display("[TB] FAIL collide_idle: got %b expected 1", IMemReqValid); end
            compared++; if (IMemReqAddr !== 32'h80) begin mismatched++; $display("[TB] FAIL collide_addr: got %h expected 80", IMemReqAddr); end
         end
         if (c == 6) begin
            compared++; if (InstrValid !== 1'b1) begin mismatched++; $display("[TB] FAIL collide_next_valid: got %b expected 1", InstrValid); end
            compared++; if (InstrPC !== 32'h80) begin mismatched++; $display("[TB] FAIL collide_next_pc: got %h expected 80", InstrPC); end
         end
      end
   endtask

   task automatic test_reset_midwait();
      doReset();
      IMemReqReady = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) tick();
         if (c == 4) memLat = 3;
         if (c == 5) Reset = 1'b1;
         if (c == 6) begin Reset = 1'b0; IMemReqReady = 1'b0; end
         if (c == 9) begin IMemReqReady = 1'b1; memLat = 1; end
         #1;
         if (c == 4) begin
            compared++; if (InstrValid !== 1'b1) begin mismatched++; $display("[TB] FAIL midwait_queued: got %b expected 1", InstrValid); end
         end
         if (c == 5) begin
            compared++; if (IMemReqValid !== 1'b0) begin mismatched++; $display("[TB] FAIL midwait_reqvalid: got %b expected 0", IMemReqValid); end
            compared++; if (PCEn !== 1'b0) begin mismatched++; $display("[TB] FAIL midwait_pcen: got %b expected 0", PCEn); end
            compared++; if (InstrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL midwait_valid: got %b expected 0", InstrValid); end
            compared++; if (Instr !== 32'h0) begin mismatched++; $display("[TB] FAIL midwait_instr: got %h expected 0", Instr); end
            compared++; if (InstrPC !== 32'h0) begin mismatched++; $display("[TB] FAIL midwait_pc: got %h expected 0", InstrPC); end
         end
         if (c >= 7 && c <= 9) begin
            compared++; if (InstrValid !== 1'b0) begin mismatched++; $display("[TB] FAIL stale_ignored c=%0d: got %b expected 0", c, InstrValid); end
         end
         if (c == 9) begin
            compared++; if (IMemReqAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL post_reset_addr: got %h expected 0", IMemReqAddr); end
         end
         if (c == 11) begin
            compared++; if (InstrValid !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_valid: got %b expected 1", InstrValid); end
            compared++; if (InstrPC !== 32'h0) begin mismatched++; $display("[TB] FAIL post_reset_pc: got %h expected 0", InstrPC); end
            compared++; if (Instr !== memWord(32'h0)) begin mismatched++; $display("[TB] FAIL post_reset_instr: got %h expected %h", Instr, memWord(32'h0)); end
         end
      end
   endtask

   task automatic test_req_stall();
      doReset();
      for (int c = 0; c < 7; c++) begin
         if (c > 0) tick();
         if (c == 5) IMemReqReady = 1'b1;
         #1;
         if (c < 5) begin
            compared++; if (IMemReqValid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_reqvalid c=%0d: got %b expected 1", c, IMemReqValid); end
            compared++; if (IMemReqAddr !== 32'h0) begin mismatched++; $display("[TB] FAIL stall_addr c=%0d: got %h expected 0", c, IMemReqAddr); end
            compared++; if (PCEn !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_pcen c=%0d: got %b expected 0", c, PCEn); end
         end
         if (c == 5) begin
            compared++; if (PCEn !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_release: got %b expected 1", PCEn); end
         end
         if (c == 6) begin
            compared++; if (IMemReqValid !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_wait: got %b expected 0", IMemReqValid); end
         end
      end
   endtask

   // Scenarios run back to back, each starting from its own reset.
   initial begin
      test_reset();
      test_streaming();
      test_fill();
      test_flush_wait();
      test_flush_collide();
      test_reset_midwait();
      test_req_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
